// File: rtl/instr_fetch_unit.sv
// ============================================================================
// instr_fetch_unit: PC owner and single-outstanding instruction fetch stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [7:0]      imem_rdata,
  output logic            out_valid,
  output logic [7:0]      out_instr,
  input  logic            out_ready,
  input  logic            dec_interrupt,
  input  logic            dec_halt,
  input  logic [3:0]      dec_immdt,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            resume,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] epc,
  output logic            halted,
  output logic            int_taken
);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT    = 2'd1,
    S_PRESENT = 2'd2,
    S_HALTED  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] epc_q, epc_d;
  logic [7:0]      instr_q, instr_d;
  logic            int_taken_q, int_taken_d;

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] int_vec;

  assign pc_inc  = pc_q + PC_W'(1);
  // Vector address is immdt*16, resized to the PC width.
  assign int_vec = PC_W'({dec_immdt, 4'b0000});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      epc_q       <= '0;
      instr_q     <= '0;
      int_taken_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      epc_q       <= epc_d;
      instr_q     <= instr_d;
      int_taken_q <= int_taken_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    epc_d       = epc_q;
    instr_d     = instr_q;
    int_taken_d = 1'b0;
    case (state_q)
      S_REQ: begin
        if (imem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (out_ready) begin
          if (dec_halt) begin
            pc_d    = pc_inc;
            state_d = S_HALTED;
          end else if (dec_interrupt) begin
            epc_d       = pc_inc;
            pc_d        = int_vec;
            int_taken_d = 1'b1;
            state_d     = S_REQ;
          end else if (redirect) begin
            pc_d    = redirect_pc;
            state_d = S_REQ;
          end else begin
            pc_d    = pc_inc;
            state_d = S_REQ;
          end
        end
      end
      S_HALTED: begin
        if (resume) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  assign imem_req  = (state_q == S_REQ);
  assign imem_addr = pc_q;
  assign out_valid = (state_q == S_PRESENT);
  assign out_instr = instr_q;
  assign pc        = pc_q;
  assign epc       = epc_q;
  assign halted    = (state_q == S_HALTED);
  assign int_taken = int_taken_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// tb_instr_fetch_unit: directed self-checking bench for instr_fetch_unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_gnt = 1'b0;
  logic       imem_rvalid = 1'b0;
  logic [7:0] imem_rdata = 8'h00;
  logic       out_valid;
  logic [7:0] out_instr;
  logic       out_ready = 1'b0;
  logic       dec_interrupt = 1'b0;
  logic       dec_halt = 1'b0;
  logic [3:0] dec_immdt = 4'h0;
  logic       redirect = 1'b0;
  logic [7:0] redirect_pc = 8'h00;
  logic       resume = 1'b0;
  logic [7:0] pc;
  logic [7:0] epc;
  logic       halted;
  logic       int_taken;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  instr_fetch_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_instr(out_instr), .out_ready(out_ready),
    .dec_interrupt(dec_interrupt), .dec_halt(dec_halt), .dec_immdt(dec_immdt),
    .redirect(redirect), .redirect_pc(redirect_pc), .resume(resume),
    .pc(pc), .epc(epc), .halted(halted), .int_taken(int_taken)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Request/grant then one-cycle-later response; ends in PRESENT.
  task automatic fetch(input logic [7:0] data);
    imem_gnt = 1'b1;
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    tick();
    imem_rvalid = 1'b0;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready     = 1'b0;
    dec_halt      = 1'b0;
    dec_interrupt = 1'b0;
    redirect      = 1'b0;
    resume        = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc got %h exp 00", pc); end
    checks++; if (epc !== 8'h00) begin errors++; $display("FAIL reset_epc got %h exp 00", epc); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (out_instr !== 8'h00) begin errors++; $display("FAIL reset_instr got %h exp 00", out_instr); end
    checks++; if (halted !== 1'b0 || int_taken !== 1'b0) begin errors++; $display("FAIL reset_flags got halted=%b int=%b exp 0 0", halted, int_taken); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_req got %b exp 1", imem_req); end
  endtask

  task automatic test_sequential();
    logic [7:0] mem [3];
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 8'(i)) begin errors++; $display("FAIL seq_req%0d got req=%b addr=%h exp 1 %h", i, imem_req, imem_addr, 8'(i)); end
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      checks++; if (imem_req !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL seq_wait%0d got req=%b valid=%b exp 0 0", i, imem_req, out_valid); end
      imem_rvalid = 1'b1; imem_rdata = mem[i];
      tick();
      imem_rvalid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_instr !== mem[i] || cyc !== 2 + 3 * i) begin
        errors++; $display("FAIL seq_out%0d got valid=%b instr=%h cyc=%0d exp 1 %h %0d", i, out_valid, out_instr, cyc, mem[i], 2 + 3 * i);
      end
      accept();
    end
    checks++; if (pc !== 8'h03) begin errors++; $display("FAIL seq_pc got %h exp 03", pc); end
  endtask

  task automatic test_backpressure();
    fetch(8'h44);
    dec_halt = 1'b1; redirect = 1'b1; redirect_pc = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_instr !== 8'h44 || pc !== 8'h03 || imem_req !== 1'b0 || halted !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d got valid=%b instr=%h pc=%h req=%b halted=%b exp 1 44 03 0 0", i, out_valid, out_instr, pc, imem_req, halted);
      end
    end
    dec_halt = 1'b0; redirect = 1'b0;
    accept();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h04) begin errors++; $display("FAIL bp_next got req=%b addr=%h exp 1 04", imem_req, imem_addr); end
  endtask

  task automatic test_redirect();
    fetch(8'h01); accept();
    checks++; if (pc !== 8'h05) begin errors++; $display("FAIL rd_setup got %h exp 05", pc); end
    fetch(8'h02);
    redirect = 1'b1; redirect_pc = 8'h40;
    accept();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h40) begin errors++; $display("FAIL rd_target got req=%b addr=%h exp 1 40", imem_req, imem_addr); end
    fetch(8'h03);
    redirect = 1'b1; redirect_pc = 8'h05;
    accept();
    fetch(8'h04);
    dec_halt = 1'b1; redirect = 1'b1; redirect_pc = 8'h40;
    accept();
    checks++; if (halted !== 1'b1 || pc !== 8'h06 || imem_req !== 1'b0) begin errors++; $display("FAIL rd_halt got halted=%b pc=%h req=%b exp 1 06 0", halted, pc, imem_req); end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    checks++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h06) begin errors++; $display("FAIL rd_resume got halted=%b req=%b addr=%h exp 0 1 06", halted, imem_req, imem_addr); end
  endtask

  task automatic test_interrupt();
    fetch(8'h05);
    redirect = 1'b1; redirect_pc = 8'h12;
    accept();
    fetch(8'h06);
    checks++; if (pc !== 8'h12 || int_taken !== 1'b0) begin errors++; $display("FAIL int_setup got pc=%h int=%b exp 12 0", pc, int_taken); end
    dec_interrupt = 1'b1; dec_immdt = 4'h3; redirect = 1'b1; redirect_pc = 8'h77;
    accept();
    checks++; if (int_taken !== 1'b1 || epc !== 8'h13 || imem_req !== 1'b1 || imem_addr !== 8'h30) begin
      errors++; $display("FAIL int_take got int=%b epc=%h req=%b addr=%h exp 1 13 1 30", int_taken, epc, imem_req, imem_addr);
    end
    tick();
    checks++; if (int_taken !== 1'b0) begin errors++; $display("FAIL int_pulse got %b exp 0", int_taken); end
  endtask

  task automatic test_halt_wrap();
    fetch(8'h07);
    redirect = 1'b1; redirect_pc = 8'hFF;
    accept();
    fetch(8'h08);
    // halt outranks interrupt; resume in the entry cycle must be dropped
    dec_halt = 1'b1; dec_interrupt = 1'b1; dec_immdt = 4'h9; resume = 1'b1;
    accept();
    checks++; if (halted !== 1'b1 || pc !== 8'h00 || epc !== 8'h13 || int_taken !== 1'b0) begin
      errors++; $display("FAIL hw_enter got halted=%b pc=%h epc=%h int=%b exp 1 00 13 0", halted, pc, epc, int_taken);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (imem_req !== 1'b0 || halted !== 1'b1) begin errors++; $display("FAIL hw_idle%0d got req=%b halted=%b exp 0 1", i, imem_req, halted); end
    end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    checks++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h00) begin errors++; $display("FAIL hw_resume got halted=%b req=%b addr=%h exp 0 1 00", halted, imem_req, imem_addr); end
  endtask

  task automatic test_reset_midfetch();
    fetch(8'h09); accept();
    checks++; if (pc !== 8'h01) begin errors++; $display("FAIL rm_setup got %h exp 01", pc); end
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 8'h99;
    tick();
    imem_rvalid = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_instr !== 8'h00 || imem_req !== 1'b1 || imem_addr !== 8'h00 || epc !== 8'h00) begin
      errors++; $display("FAIL rm_state got valid=%b instr=%h req=%b addr=%h epc=%h exp 0 00 1 00 00", out_valid, out_instr, imem_req, imem_addr, epc);
    end
    tick();
    checks++; if (out_valid !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL rm_stay got valid=%b req=%b exp 0 1", out_valid, imem_req); end
  endtask

  initial begin
    tick();
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_interrupt();
    test_halt_wrap();
    test_reset_midfetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
